// File: rtl/ring_noc_pkg.sv
// Shared definitions for the ring router switch-allocation logic.
//   - Default packet layout: slot-valid bit on top, 16-bit timestamp below it.
//   - Route codes and the traffic-class encoding used by the allocator.
//   - ts_older(): wrap-aware age compare for default-width timestamps.
package ring_noc_pkg;

   localparam int PKT_VALID_BIT = 48;
   localparam int TS_MSB_DEF    = 47;
   localparam int TS_LSB_DEF    = 32;
   localparam int TS_W_DEF      = TS_MSB_DEF - TS_LSB_DEF + 1;
   localparam int ROUTE_W       = 16;

   localparam logic [ROUTE_W-1:0] ROUTE_NONE  = 16'h0000;
   localparam logic [ROUTE_W-1:0] ROUTE_PORT0 = 16'h0001;

   typedef enum logic {
      CLASS_LOW  = 1'b0,
      CLASS_HIGH = 1'b1
   } prio_class_e;

   // a is older than b when (a - b) mod 2^TS_W has its MSB set, so the
   // compare survives timestamp wrap as long as live ages span < 2^(TS_W-1).
   function automatic logic ts_older(input logic [TS_W_DEF-1:0] a,
                                     input logic [TS_W_DEF-1:0] b);
      logic [TS_W_DEF-1:0] diff;
      diff = a - b;
      return diff[TS_W_DEF-1];
   endfunction

endpackage

// File: rtl/ring_age_switch_allocator_oldest_select.sv
// Oldest-slot finder for one traffic class.
//   valid  in   [DEPTH]        slot participates in the search
//   ts     in   [DEPTH][TS_W]  slot timestamps
//   found  out  1              at least one valid slot
//   idx    out  $clog2(DEPTH)  index of the oldest valid slot (ties -> lower index)
// A balanced binary tree over the slots padded to a power of two; padding
// leaves are never valid. The left subtree always holds the lower indices,
// so preferring the left child on equal age gives the lower-index tie-break.
module oldest_select #(
   parameter int DEPTH = 4,
   parameter int TS_W  = 16
) (
   input  logic [DEPTH-1:0]           valid,
   input  logic [DEPTH-1:0][TS_W-1:0] ts,
   output logic                       found,
   output logic [$clog2(DEPTH)-1:0]   idx
);

   localparam int IDX_W  = $clog2(DEPTH);
   localparam int LEAVES = 1 << IDX_W;

   // Heap layout: node n has children 2n and 2n+1, leaves at LEAVES+i.
   logic             node_v   [2*LEAVES];
   logic [TS_W-1:0]  node_ts  [2*LEAVES];
   logic [IDX_W-1:0] node_idx [2*LEAVES];

   function automatic logic older(input logic [TS_W-1:0] a, input logic [TS_W-1:0] b);
      logic [TS_W-1:0] diff;
      diff = a - b;
      return diff[TS_W-1];
   endfunction

   always_comb begin
      for (int n = 0; n < 2*LEAVES; n++) begin
         node_v[n]   = 1'b0;
         node_ts[n]  = '0;
         node_idx[n] = '0;
      end
      for (int i = 0; i < LEAVES; i++) begin
         node_idx[LEAVES+i] = IDX_W'(i);
      end
      for (int i = 0; i < DEPTH; i++) begin
         node_v[LEAVES+i]  = valid[i];
         node_ts[LEAVES+i] = ts[i];
      end
      // Take the left child unless it is absent or the right one is strictly older.
      for (int n = LEAVES-1; n >= 1; n--) begin
         if (node_v[2*n] && (!node_v[2*n+1] || !older(node_ts[2*n+1], node_ts[2*n]))) begin
            node_v[n]   = 1'b1;
            node_ts[n]  = node_ts[2*n];
            node_idx[n] = node_idx[2*n];
         end else begin
            node_v[n]   = node_v[2*n+1];
            node_ts[n]  = node_ts[2*n+1];
            node_idx[n] = node_idx[2*n+1];
         end
      end
   end

   assign found = node_v[1];
   assign idx   = node_idx[1];

endmodule

// File: rtl/ring_age_switch_allocator.sv
// Per-output-port switch allocator for the ring router.
// Picks the oldest eligible packet among DEPTH high- and DEPTH low-priority
// slots and registers it into a one-entry valid/ready output stage. An aging
// counter bounds how long eligible low-priority traffic can be bypassed.
//   clk, rst_n    clock, asynchronous active-low reset
//   hi_pkt/lo_pkt slot contents, bit PACKET_SIZE-1 = slot valid
//   hi_route      high slot eligible when non-zero
//   lo_route      low slot eligible when equal to OUT_PORT
//   hi_pop/lo_pop one-hot grant, combinational, buffer removes at the edge
//   out_ready     downstream accepts out_packet this cycle
//   out_valid     out_packet holds a granted packet
//   out_packet    granted packet
//   out_src_high  1 = granted from the high class
//   out_src_idx   slot index the packet came from
module ring_age_switch_allocator
   import ring_noc_pkg::*;
#(
   parameter logic [ROUTE_W-1:0] OUT_PORT     = ROUTE_PORT0,
   parameter int                 PACKET_SIZE  = PKT_VALID_BIT + 1,
   parameter int                 DEPTH        = 4,
   parameter int                 TS_MSB       = TS_MSB_DEF,
   parameter int                 TS_LSB       = TS_LSB_DEF,
   parameter int                 STARVE_LIMIT = 4
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [DEPTH-1:0][PACKET_SIZE-1:0]   hi_pkt,
   input  logic [DEPTH-1:0][ROUTE_W-1:0]       hi_route,
   input  logic [DEPTH-1:0][PACKET_SIZE-1:0]   lo_pkt,
   input  logic [DEPTH-1:0][ROUTE_W-1:0]       lo_route,
   output logic [DEPTH-1:0]                    hi_pop,
   output logic [DEPTH-1:0]                    lo_pop,
   input  logic                                out_ready,
   output logic                                out_valid,
   output logic [PACKET_SIZE-1:0]              out_packet,
   output logic                                out_src_high,
   output logic [$clog2(DEPTH)-1:0]            out_src_idx
);

   localparam int              IDX_W  = $clog2(DEPTH);
   localparam int              TS_W   = TS_MSB - TS_LSB + 1;
   localparam int              SC_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);

   logic [DEPTH-1:0]           hi_elig;
   logic [DEPTH-1:0]           lo_elig;
   logic [DEPTH-1:0][TS_W-1:0] hi_ts;
   logic [DEPTH-1:0][TS_W-1:0] lo_ts;
   logic                       any_hi;
   logic                       any_lo;
   logic [IDX_W-1:0]           hi_idx;
   logic [IDX_W-1:0]           lo_idx;
   logic [SC_W-1:0]            starve_cnt;
   logic                       load_en;
   logic                       grant;
   prio_class_e                sel_class;
   logic [IDX_W-1:0]           sel_idx;
   logic [PACKET_SIZE-1:0]     sel_pkt;

   always_comb begin
      hi_elig = '0;
      lo_elig = '0;
      hi_ts   = '0;
      lo_ts   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         hi_elig[i] = hi_pkt[i][PACKET_SIZE-1] && (hi_route[i] != ROUTE_NONE);
         lo_elig[i] = lo_pkt[i][PACKET_SIZE-1] && (lo_route[i] == OUT_PORT);
         hi_ts[i]   = hi_pkt[i][TS_MSB:TS_LSB];
         lo_ts[i]   = lo_pkt[i][TS_MSB:TS_LSB];
      end
   end

   oldest_select #(.DEPTH(DEPTH), .TS_W(TS_W)) u_hi_sel (
      .valid (hi_elig),
      .ts    (hi_ts),
      .found (any_hi),
      .idx   (hi_idx)
   );

   oldest_select #(.DEPTH(DEPTH), .TS_W(TS_W)) u_lo_sel (
      .valid (lo_elig),
      .ts    (lo_ts),
      .found (any_lo),
      .idx   (lo_idx)
   );

   // Low wins when it is the only class present, or when high has already
   // been granted STARVE_LIMIT times in a row over an eligible low slot.
   // rst_n gates the grant so no pop escapes while reset is held.
   always_comb begin
      load_en   = !out_valid || out_ready;
      grant     = rst_n && load_en && (any_hi || any_lo);
      sel_class = (any_lo && (!any_hi || (starve_cnt == SC_MAX))) ? CLASS_LOW : CLASS_HIGH;
      sel_idx   = (sel_class == CLASS_LOW) ? lo_idx : hi_idx;
      sel_pkt   = (sel_class == CLASS_LOW) ? lo_pkt[lo_idx] : hi_pkt[hi_idx];
   end

   always_comb begin
      hi_pop = '0;
      lo_pop = '0;
      if (grant) begin
         if (sel_class == CLASS_LOW) begin
            lo_pop[lo_idx] = 1'b1;
         end else begin
            hi_pop[hi_idx] = 1'b1;
         end
      end
   end

   // Counts consecutive high grants that bypassed an eligible low slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (load_en) begin
         if (!any_lo || (sel_class == CLASS_LOW)) begin
            starve_cnt <= '0;
         end else if (starve_cnt != SC_MAX) begin
            starve_cnt <= starve_cnt + SC_W'(1);
         end
      end
   end

   // One-entry output stage; holds everything while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         out_packet   <= '0;
         out_src_high <= 1'b0;
         out_src_idx  <= '0;
      end else if (load_en) begin
         out_valid <= grant;
         if (grant) begin
            out_packet   <= sel_pkt;
            out_src_high <= (sel_class == CLASS_HIGH);
            out_src_idx  <= sel_idx;
         end
      end
   end

endmodule

// File: tb/tb_ring_age_switch_allocator.sv
module tb_ring_age_switch_allocator;

   localparam int LIMIT = 4;

   typedef struct packed {
      logic [48:0] pkt;
      logic        hi;
      logic [1:0]  idx;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [3:0][48:0]  hi_pkt, lo_pkt;
   logic [3:0][15:0]  hi_route, lo_route;
   logic [3:0]        hi_pop, lo_pop;
   logic              out_ready;
   logic              out_valid;
   logic [48:0]       out_packet;
   logic              out_src_high;
   logic [1:0]        out_src_idx;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t q[$];
   bit   pushed_now = 1'b0;
   bit   m_ov = 1'b0;
   int   m_starve = 0;
   logic [3:0] cap_hi_pop, cap_lo_pop;
   logic [15:0] base_ts;

   ring_age_switch_allocator #(
      .OUT_PORT(16'h0001), .PACKET_SIZE(49), .DEPTH(4),
      .TS_MSB(47), .TS_LSB(32), .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .hi_pkt(hi_pkt), .hi_route(hi_route),
      .lo_pkt(lo_pkt), .lo_route(lo_route),
      .hi_pop(hi_pop), .lo_pop(lo_pop),
      .out_ready(out_ready), .out_valid(out_valid), .out_packet(out_packet),
      .out_src_high(out_src_high), .out_src_idx(out_src_idx)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // a older than b: (a-b) mod 65536 lies in the upper half.
   function automatic bit m_older(input logic [15:0] a, input logic [15:0] b);
      int d;
      d = (int'(a) - int'(b) + 65536) % 65536;
      return d >= 32768;
   endfunction

   // The oldest eligible slot is the one no other eligible slot is older than
   // and no lower-indexed slot ties with.
   function automatic int m_oldest(input logic [3:0] elig, input logic [3:0][15:0] ts);
      bit ok;
      for (int i = 0; i < 4; i++) begin
         if (elig[i]) begin
            ok = 1'b1;
            for (int j = 0; j < 4; j++) begin
               if (j != i && elig[j]) begin
                  if (m_older(ts[j], ts[i])) ok = 1'b0;
                  if (j < i && ts[j] == ts[i]) ok = 1'b0;
               end
            end
            if (ok) return i;
         end
      end
      return -1;
   endfunction

   function automatic logic [48:0] mk_pkt(input logic [15:0] ts);
      logic [31:0] pay;
      pay = $urandom;
      return {1'b1, ts, pay};
   endfunction

   task automatic clear_all();
      hi_pkt = '0; lo_pkt = '0; hi_route = '0; lo_route = '0;
   endtask

   // One clock of stimulus: predict the grant, check pops, queue the expected
   // output, then let the model buffers remove what was granted.
   task automatic cycle();
      logic [3:0] he, le, ehp, elp;
      logic [3:0][15:0] hts, lts;
      logic [48:0] p;
      int hw, lw;
      bit any_hi, any_lo, load_en, pick_lo, grant;
      exp_t e;
      @(negedge clk);
      #1;
      cap_hi_pop = hi_pop;
      cap_lo_pop = lo_pop;
      if (!rst_n) begin
         check("pops_in_reset", {hi_pop, lo_pop}, 8'h00);
         pushed_now = 1'b0;
         @(posedge clk);
         #1;
         return;
      end
      for (int i = 0; i < 4; i++) begin
         p = hi_pkt[i];
         he[i] = p[48] && (hi_route[i] != 16'h0000);
         hts[i] = p[47:32];
         p = lo_pkt[i];
         le[i] = p[48] && (lo_route[i] == 16'h0001);
         lts[i] = p[47:32];
      end
      hw = m_oldest(he, hts);
      lw = m_oldest(le, lts);
      any_hi  = (he != 4'b0);
      any_lo  = (le != 4'b0);
      load_en = !m_ov || out_ready;
      pick_lo = any_lo && (!any_hi || m_starve == LIMIT);
      grant   = load_en && (any_hi || any_lo);
      ehp = '0;
      elp = '0;
      if (grant) begin
         if (pick_lo) elp[lw] = 1'b1;
         else         ehp[hw] = 1'b1;
      end
      check("hi_pop", hi_pop, ehp);
      check("lo_pop", lo_pop, elp);
      if (load_en) begin
         if (!any_lo || (grant && pick_lo)) m_starve = 0;
         else if (grant && m_starve < LIMIT) m_starve++;
         m_ov = grant;
      end
      pushed_now = grant;
      if (grant) begin
         e.pkt = pick_lo ? lo_pkt[lw] : hi_pkt[hw];
         e.hi  = !pick_lo;
         e.idx = pick_lo ? 2'(lw) : 2'(hw);
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      if (grant) begin
         if (pick_lo) lo_pkt[lw] = '0;
         else         hi_pkt[hw] = '0;
      end
   endtask

   // Monitor: compares whatever the output stage presents with the queue head.
   initial begin
      exp_t e;
      bit exp_v;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            check("out_valid_in_reset", out_valid, 1'b0);
         end else begin
            exp_v = (q.size() - int'(pushed_now)) > 0;
            check("out_valid", out_valid, exp_v);
            if (out_valid && q.size() > 0) begin
               e = q[0];
               check("out_packet", out_packet, e.pkt);
               check("out_src_high", out_src_high, e.hi);
               check("out_src_idx", out_src_idx, e.idx);
               if (out_ready) void'(q.pop_front());
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [48:0] held;
      logic [48:0] p;
      out_ready = 1'b1;
      rst_n = 1'b1;
      clear_all();
      for (int i = 0; i < 4; i++) begin
         hi_pkt[i] = mk_pkt(16'(20 - i)); hi_route[i] = 16'h0003;
         lo_pkt[i] = mk_pkt(16'(10 + i)); lo_route[i] = 16'h0001;
      end
      #1 rst_n = 1'b0;

      // Reset with all slots valid
      cycle();
      cycle();
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_packet", out_packet, 49'h0);
      check("rst_out_src_high", out_src_high, 1'b0);
      check("rst_out_src_idx", out_src_idx, 2'b00);
      rst_n = 1'b1;
      cycle();
      check("post_rst_hi_pop", cap_hi_pop, 4'b1000);
      cycle();

      // Age order {5,2,9,2}
      clear_all();
      hi_pkt[0] = mk_pkt(16'd5); hi_pkt[1] = mk_pkt(16'd2);
      hi_pkt[2] = mk_pkt(16'd9); hi_pkt[3] = mk_pkt(16'd2);
      hi_route = {4{16'h0001}};
      cycle();
      check("age_hi_pop", cap_hi_pop, 4'b0010);
      check("age_src_idx", out_src_idx, 2'd1);
      p = out_packet;
      check("age_ts", p[47:32], 16'd2);
      repeat (4) cycle();

      // Timestamp wrap
      clear_all();
      hi_pkt[0] = mk_pkt(16'hFFF0); hi_pkt[1] = mk_pkt(16'h0005);
      hi_route[0] = 16'h0001; hi_route[1] = 16'h0001;
      cycle();
      check("wrap_first", cap_hi_pop, 4'b0001);
      cycle();
      check("wrap_second", cap_hi_pop, 4'b0010);
      cycle();

      // Starvation: high refilled every cycle, one low eligible
      clear_all();
      cycle();
      lo_pkt[0] = mk_pkt(16'd100); lo_route[0] = 16'h0001;
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < 4; i++) begin
            p = hi_pkt[i];
            if (!p[48]) begin hi_pkt[i] = mk_pkt(16'(200 + k)); hi_route[i] = 16'h0001; end
         end
         cycle();
         if (k < 4) check("starve_hi_phase", cap_lo_pop, 4'b0000);
         if (k == 4) check("starve_lo_grant", cap_lo_pop, 4'b0001);
         if (k == 5) check("starve_after_lo", cap_lo_pop, 4'b0000);
      end

      // Backpressure
      out_ready = 1'b0;
      held = out_packet;
      for (int k = 0; k < 3; k++) begin
         cycle();
         check("bp_pops", {cap_hi_pop, cap_lo_pop}, 8'h00);
         check("bp_valid", out_valid, 1'b1);
         check("bp_hold", out_packet, held);
      end
      out_ready = 1'b1;
      cycle();
      check("bp_release_pop", (cap_hi_pop | cap_lo_pop) != 4'b0, 1'b1);
      check("bp_release_valid", out_valid, 1'b1);
      repeat (4) cycle();

      // Ineligible low route
      clear_all();
      lo_pkt[0] = mk_pkt(16'd7); lo_route[0] = 16'h0002;
      repeat (3) begin
         cycle();
         check("inelig_pops", {cap_hi_pop, cap_lo_pop}, 8'h00);
      end
      check("inelig_valid", out_valid, 1'b0);

      // Randomized traffic
      clear_all();
      base_ts = 16'hFF80;
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < 4; i++) begin
            p = hi_pkt[i];
            if (!p[48] && $urandom_range(0, 1) == 1) begin
               hi_pkt[i] = mk_pkt(base_ts + 16'($urandom_range(0, 200)));
               hi_route[i] = 16'($urandom_range(0, 3));
            end
            p = lo_pkt[i];
            if (!p[48] && $urandom_range(0, 1) == 1) begin
               lo_pkt[i] = mk_pkt(base_ts + 16'($urandom_range(0, 200)));
               lo_route[i] = 16'($urandom_range(0, 2));
            end
            if ($urandom_range(0, 15) == 0) lo_route[i] = 16'($urandom_range(0, 2));
         end
         out_ready = ($urandom_range(0, 3) != 0);
         base_ts = base_ts + 16'd1;
         cycle();
      end

      // Asynchronous reset while a packet is held
      out_ready = 1'b0;
      clear_all();
      hi_pkt[2] = mk_pkt(base_ts); hi_route[2] = 16'h0001;
      repeat (3) cycle();
      #2 rst_n = 1'b0;
      #1;
      check("midrst_valid", out_valid, 1'b0);
      check("midrst_packet", out_packet, 49'h0);
      check("midrst_pops", {hi_pop, lo_pop}, 8'h00);
      q.delete();
      m_ov = 1'b0;
      m_starve = 0;
      pushed_now = 1'b0;
      hi_pkt[1] = mk_pkt(base_ts - 16'd3); hi_route[1] = 16'h0001;
      cycle();
      rst_n = 1'b1;
      out_ready = 1'b1;
      cycle();
      check("midrst_regrant", cap_hi_pop, 4'b0010);
      repeat (4) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
